// File: rtl/core_ldst_mult_seq_pkg.sv
// Shared micro-architecture types for the LDM/STM block-transfer sequencer.
// Optional abort support elsewhere is enabled with CORE_LDST_MULT_ABORT_EN.
package core_ldst_mult_seq_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int NREGS_DEF  = 16;
    localparam int WORD_BYTES = 4;

    typedef logic [ADDR_W_DEF-1:0]         word;
    typedef logic [$clog2(NREGS_DEF)-1:0]  reg_num;
    typedef logic [NREGS_DEF-1:0]          reg_list;

    // Encoded as {increment, pre_index}
    typedef enum logic [1:0] {
        DA = 2'b00,
        DB = 2'b01,
        IA = 2'b10,
        IB = 2'b11
    } ldst_mult_mode;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FIN
    } seq_state;

    function automatic ldst_mult_mode mode_of(input logic increment, input logic pre_index);
        return ldst_mult_mode'({increment, pre_index});
    endfunction

endpackage

// File: rtl/core_ldst_mult_seq_if.sv
// Issue-side and memory-side signals of the LDM/STM sequencer.
// mem_fault/fault exist only when CORE_LDST_MULT_ABORT_EN is defined.
interface core_ldst_mult_seq_if #(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16
);
    localparam int RW = $clog2(NREGS);

    logic              start;
    logic [ADDR_W-1:0] base;
    logic [NREGS-1:0]  reg_list;
    logic              increment;
    logic              pre_index;
    logic              load;
    logic              writeback;
    logic              busy;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic              mem_ready;
    logic [RW-1:0]     xfer_reg;
    logic              xfer_last;
    logic              done;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_value;
`ifdef CORE_LDST_MULT_ABORT_EN
    logic              mem_fault;
    logic              fault;

    // Sequencer side
    modport master (
        input  start, base, reg_list, increment, pre_index, load, writeback,
        input  mem_ready, mem_fault,
        output busy, mem_valid, mem_addr, mem_write, xfer_reg, xfer_last,
        output done, wb_en, wb_value, fault
    );

    // Issue / memory side
    modport slave (
        output start, base, reg_list, increment, pre_index, load, writeback,
        output mem_ready, mem_fault,
        input  busy, mem_valid, mem_addr, mem_write, xfer_reg, xfer_last,
        input  done, wb_en, wb_value, fault
    );
`else
    // Sequencer side
    modport master (
        input  start, base, reg_list, increment, pre_index, load, writeback,
        input  mem_ready,
        output busy, mem_valid, mem_addr, mem_write, xfer_reg, xfer_last,
        output done, wb_en, wb_value
    );

    // Issue / memory side
    modport slave (
        output start, base, reg_list, increment, pre_index, load, writeback,
        output mem_ready,
        input  busy, mem_valid, mem_addr, mem_write, xfer_reg, xfer_last,
        input  done, wb_en, wb_value
    );
`endif

endinterface

// File: rtl/core_ldst_mult_prio.sv
// Lowest-set-bit encoder and popcount over a register list.
module core_ldst_mult_prio #(
    parameter int NREGS = 16
) (
    input  logic [NREGS-1:0]           i_list,
    output logic [$clog2(NREGS)-1:0]   o_index,
    output logic                       o_valid,
    output logic                       o_one_left,
    output logic [$clog2(NREGS+1)-1:0] o_count
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS+1);

    // Scan high to low so the lowest set bit is the final assignment
    always_comb begin
        o_index = '0;
        o_count = '0;
        for (int unsigned i = NREGS; i > 0; i--) begin
            if (i_list[i-1]) o_index = RW'(i - 1);
        end
        for (int unsigned i = 0; i < NREGS; i++) begin
            o_count = o_count + CW'(i_list[i]);
        end
        o_valid    = |i_list;
        o_one_left = (o_count == CW'(1));
    end

endmodule

// File: rtl/core_ldst_mult_seq.sv
// LDM/STM sequencer: one word transaction per listed register, lowest
// register at lowest address, then a base writeback value.
// Build option CORE_LDST_MULT_ABORT_EN adds mem_fault/fault abort handling.
module core_ldst_mult_seq
    import core_ldst_mult_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREGS  = 16
) (
    input  logic clk,
    input  logic rst,
    core_ldst_mult_seq_if.master bus
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS+1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    seq_state          r_state;
    seq_state          w_next;
    logic [NREGS-1:0]  r_list;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wb_value;
    logic              r_load;
    logic              r_wb;
    logic              r_fault;

    logic [NREGS-1:0]  w_prio_in;
    logic [RW-1:0]     w_idx;
    logic              w_valid;
    logic              w_one_left;
    logic [CW-1:0]     w_count;
    logic [ADDR_W-1:0] w_n4;
    logic [ADDR_W-1:0] w_first;
    logic [ADDR_W-1:0] w_wb_calc;
    logic              w_accept;
    logic              w_fault_in;

`ifdef CORE_LDST_MULT_ABORT_EN
    assign w_fault_in = bus.mem_fault;
`else
    assign w_fault_in = 1'b0;
`endif

    // One encoder serves both: incoming list for sizing in IDLE, remaining list otherwise
    assign w_prio_in = (r_state == IDLE) ? bus.reg_list : r_list;

    core_ldst_mult_prio #(.NREGS(NREGS)) u_prio (
        .i_list     (w_prio_in),
        .o_index    (w_idx),
        .o_valid    (w_valid),
        .o_one_left (w_one_left),
        .o_count    (w_count)
    );

    assign w_n4     = ADDR_W'({w_count, 2'b00});
    assign w_accept = (r_state == XFER) && bus.mem_ready;

    // First address and final base value for the requested addressing mode
    always_comb begin
        w_wb_calc = bus.increment ? (bus.base + w_n4) : (bus.base - w_n4);
        case (mode_of(bus.increment, bus.pre_index))
            IA:      w_first = bus.base;
            IB:      w_first = bus.base + STEP;
            DA:      w_first = bus.base - w_n4 + STEP;
            DB:      w_first = bus.base - w_n4;
            default: w_first = bus.base;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and all outputs, decoded from the current state
    always_comb begin
        w_next        = r_state;
        bus.busy      = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_write = 1'b0;
        bus.xfer_reg  = '0;
        bus.xfer_last = 1'b0;
        bus.done      = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_value  = '0;
`ifdef CORE_LDST_MULT_ABORT_EN
        bus.fault     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = w_valid ? XFER : FIN;
            end
            XFER: begin
                bus.busy      = 1'b1;
                bus.mem_valid = 1'b1;
                bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                bus.mem_write = ~r_load;
                bus.xfer_reg  = w_idx;
                bus.xfer_last = w_one_left;
                if (w_accept && (w_one_left || w_fault_in)) w_next = FIN;
            end
            FIN: begin
                bus.done     = 1'b1;
                bus.wb_en    = r_wb & ~r_fault;
                bus.wb_value = r_wb_value;
`ifdef CORE_LDST_MULT_ABORT_EN
                bus.fault    = r_fault;
`endif
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Transfer context: latched at start, stepped on each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_list     <= '0;
            r_addr     <= '0;
            r_wb_value <= '0;
            r_load     <= 1'b0;
            r_wb       <= 1'b0;
            r_fault    <= 1'b0;
        end else if (r_state == IDLE) begin
            if (bus.start) begin
                r_list     <= bus.reg_list;
                r_addr     <= w_first;
                r_wb_value <= w_wb_calc;
                r_load     <= bus.load;
                r_wb       <= bus.writeback;
                r_fault    <= 1'b0;
            end
        end else if (w_accept) begin
            // x & (x-1) drops the lowest set bit, i.e. the register just transferred
            r_list  <= r_list & (r_list - NREGS'(1));
            r_addr  <= r_addr + STEP;
            r_fault <= w_fault_in;
        end
    end

endmodule
